// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-side definitions: widths, NOP encoding, fetch states and queue payload.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] data;
  } fetch_entry_t;

  // Sequential word address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] a);
    return a + XLEN'(4);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// In-order FIFO of fetched {addr, data} words; flush wins over push and pop.
module fetch_queue
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  // Pointer increment that also handles non-power-of-two depths.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && (cnt != CW'(DEPTH));
  assign do_pop  = pop && (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: credit-limited sequential prefetch, redirect on pc mismatch, NOP bubbles on stall.
module inst_fetch_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [ILEN-1:0] NOP_INST = RV_NOP,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic [ILEN-1:0] inst,
  output logic            inst_valid,
  output logic            fetch_stall
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] exp_pc;
  logic [XLEN-1:0] tail_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard_cnt;

  logic [CW-1:0]   occupancy;
  logic [CW:0]     used;
  logic            q_full;
  logic            q_empty;
  logic            q_push;
  fetch_entry_t    q_head;
  fetch_entry_t    q_in;

  logic            redirect;
  logic            credit_ok;
  logic            req_fire;
  logic            resp_ok;
  logic [CW-1:0]   outstanding_dec;
  logic [CW-1:0]   discard_dec;

  assign redirect  = (state == S_FETCH) && (pc != exp_pc);
  assign used      = {1'b0, occupancy} + {1'b0, outstanding};
  assign credit_ok = !q_full && (used < (CW+1)'(DEPTH));

  assign imem_req_valid = rst && (state == S_FETCH) && !redirect && credit_ok;
  assign imem_req_addr  = fpc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing in flight belongs to a request lost across reset.
  assign resp_ok         = rst && imem_resp_valid && (outstanding != '0);
  assign outstanding_dec = outstanding - CW'(resp_ok);
  assign discard_dec     = discard_cnt - CW'(resp_ok);

  assign q_push = (state == S_FETCH) && !redirect && resp_ok;
  assign q_in   = '{addr: tail_pc, data: imem_resp_data};

  assign inst_valid  = rst && (state == S_FETCH) && !q_empty && (q_head.addr == pc);
  assign inst        = inst_valid ? q_head.data : NOP_INST;
  assign fetch_stall = !inst_valid;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_in),
    .pop       (inst_valid),
    .flush     (redirect),
    .full      (q_full),
    .empty     (q_empty),
    .count     (occupancy),
    .head      (q_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_FETCH;
      fpc         <= RESET_PC;
      exp_pc      <= RESET_PC;
      tail_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (redirect) begin
            // Everything still in flight (minus a word landing now) is stale.
            outstanding <= outstanding_dec;
            discard_cnt <= outstanding_dec;
            fpc         <= pc;
            exp_pc      <= pc;
            tail_pc     <= pc;
            state       <= (outstanding_dec != '0) ? S_DRAIN : S_FETCH;
          end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
            if (req_fire)   fpc     <= next_word(fpc);
            if (resp_ok)    tail_pc <= next_word(tail_pc);
            if (inst_valid) exp_pc  <= next_word(exp_pc);
          end
        end
        S_DRAIN: begin
          // Track pc so a further redirect needs no extra discard.
          outstanding <= outstanding_dec;
          discard_cnt <= discard_dec;
          fpc         <= pc;
          exp_pc      <= pc;
          tail_pc     <= pc;
          if (discard_dec == '0) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Credit rule keeps the queue from ever overflowing on a response.
  a_credit: assert property (@(posedge clk) disable iff (!rst)
    used <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: memory model, control-unit pc driver and delivery scoreboard.
module tb_inst_fetch_unit;
  import rv32i_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_stall;

  inst_fetch_unit #(
    .DEPTH    (4),
    .NOP_INST (NOP),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst            (inst),
    .inst_valid      (inst_valid),
    .fetch_stall     (fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_req[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int lat = 1;
  int hs_cnt = 0;
  int ready_limit = 1000;
  int deliv_cnt = 0;
  int last_deliv_cyc = 0;
  int rel_cyc = 0;
  bit mem_hold = 0;
  bit chk_drain = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Control unit moves pc; the word at the new pc becomes the next expected delivery.
  task automatic set_pc(input logic [31:0] a);
    pc = a;
    exp_q.delete();
    exp_q.push_back(mem_word(a));
  endtask

  task automatic tick();
    logic iv;
    #1;
    iv = inst_valid;
    check("stall", 32'(fetch_stall), 32'(!inst_valid));
    if (!inst_valid) check("nop", inst, NOP);
    if (imem_req_valid && imem_req_ready) begin
      hs_cnt++;
      if (chk_drain) begin
        check("drain_first", 32'(pend.size()), 32'd0);
        chk_drain = 0;
      end
      pend.push_back('{addr: imem_req_addr, due: cyc + lat});
      if (exp_req.size() != 0) check("req_addr", imem_req_addr, exp_req.pop_front());
    end
    if (iv) begin
      if (exp_q.size() == 0) check("spurious_valid", 32'(iv), 32'd0);
      else check("inst", inst, exp_q.pop_front());
      deliv_cnt++;
      last_deliv_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (iv) set_pc(pc + 32'd4);
    imem_resp_valid = 1'b0;
    if (rst && !mem_hold && pend.size() != 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    imem_req_ready = (hs_cnt < ready_limit);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    pend.delete();
    exp_req.delete();
    imem_resp_valid = 1'b0;
    mem_hold = 0;
    chk_drain = 0;
    ready_limit = 1000;
    hs_cnt = 0;
    imem_req_ready = 1'b1;
    set_pc(32'h0);
    repeat (n) tick();
  endtask

  task automatic release_rst();
    rst = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic run_deliv(input string tag, input int n, input int budget);
    int start;
    int b;
    start = deliv_cnt;
    b = 0;
    while ((deliv_cnt - start) < n && b < budget) begin
      tick();
      b++;
    end
    check(tag, 32'(deliv_cnt - start), 32'(n));
  endtask

  task automatic reset_outputs(input string tag);
    #1;
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_inst"}, inst, NOP);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_stall"}, 32'(fetch_stall), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    pc = '0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    @(negedge clk);

    // Reset then sequential fetch at latency 1.
    do_reset(2);
    reset_outputs("rst");
    release_rst();
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    #1;
    check("t1_first_req", 32'(imem_req_valid), 32'd1);
    check("t1_first_stall", 32'(fetch_stall), 32'd1);
    run_deliv("t1_deliv", 3, 20);
    check("t1_back_to_back", 32'(last_deliv_cyc - rel_cyc), 32'd4);
    check("t1_reqs_left", 32'(exp_req.size()), 32'd0);

    // Credit limit: no responses, four requests only.
    do_reset(2);
    mem_hold = 1;
    release_rst();
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_req.push_back(32'hC);
    repeat (10) tick();
    check("t2_hs", 32'(hs_cnt), 32'd4);
    #1;
    check("t2_blocked", 32'(imem_req_valid), 32'd0);
    mem_hold = 0;
    exp_req.push_back(32'h10);
    run_deliv("t2_deliv", 4, 30);
    check("t2_reqs_left", 32'(exp_req.size()), 32'd0);

    // Redirect with three words in flight.
    do_reset(2);
    mem_hold = 1;
    ready_limit = 3;
    release_rst();
    repeat (6) tick();
    check("t3_hs", 32'(hs_cnt), 32'd3);
    set_pc(32'h100);
    tick();
    check("t3_state", 32'(dut.state), 32'(S_DRAIN));
    check("t3_discard", 32'(dut.discard_cnt), 32'd3);
    mem_hold = 0;
    ready_limit = 1000;
    imem_req_ready = 1'b1;
    chk_drain = 1;
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    run_deliv("t3_deliv", 2, 40);
    check("t3_reqs_left", 32'(exp_req.size()), 32'd0);

    // Redirect coincident with a response.
    do_reset(2);
    mem_hold = 1;
    ready_limit = 2;
    release_rst();
    repeat (5) tick();
    check("t4_hs", 32'(hs_cnt), 32'd2);
    set_pc(32'h200);
    mem_hold = 0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = mem_word(pend[0].addr);
    void'(pend.pop_front());
    tick();
    check("t4_state", 32'(dut.state), 32'(S_DRAIN));
    check("t4_discard", 32'(dut.discard_cnt), 32'd1);
    ready_limit = 1000;
    imem_req_ready = 1'b1;
    chk_drain = 1;
    exp_req.push_back(32'h200);
    run_deliv("t4_deliv", 2, 40);
    check("t4_reqs_left", 32'(exp_req.size()), 32'd0);

    // Address wrap past the top of memory.
    do_reset(2);
    ready_limit = 0;
    imem_req_ready = 1'b0;
    release_rst();
    repeat (2) tick();
    check("t5_no_hs", 32'(hs_cnt), 32'd0);
    set_pc(32'hFFFF_FFF8);
    ready_limit = 1000;
    imem_req_ready = 1'b1;
    exp_req.push_back(32'hFFFF_FFF8);
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0000_0000);
    run_deliv("t5_deliv", 3, 30);
    check("t5_reqs_left", 32'(exp_req.size()), 32'd0);

    // Reset while draining.
    do_reset(2);
    mem_hold = 1;
    ready_limit = 3;
    release_rst();
    repeat (6) tick();
    set_pc(32'h300);
    tick();
    check("t6_state_drain", 32'(dut.state), 32'(S_DRAIN));
    rst = 1'b0;
    pend.delete();
    reset_outputs("t6_rst");
    tick();
    check("t6_state", 32'(dut.state), 32'(S_FETCH));
    check("t6_fpc", dut.fpc, 32'h0);
    check("t6_outstanding", 32'(dut.outstanding), 32'd0);
    check("t6_discard", 32'(dut.discard_cnt), 32'd0);
    set_pc(32'h0);
    mem_hold = 0;
    ready_limit = 1000;
    hs_cnt = 0;
    imem_req_ready = 1'b1;
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    release_rst();
    run_deliv("t6_deliv", 2, 30);
    check("t6_reqs_left", 32'(exp_req.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
